// File: rtl/button_reset_ctrl_pkg.sv
// Board-level constants and helpers shared by the button/reset conditioning block.
// Latency: n/a (constants and a constant function only).
// Backpressure: n/a.
package button_reset_ctrl_pkg;

  // 25 MHz board clock.
  localparam int CLK25_HZ = 25_000_000;

  // 10 ms of stable level before a press or release is believed.
  localparam int DEBOUNCE_CYCLES_DEF = CLK25_HZ / 100;

  // Minimum time the apple1 core is held in reset.
  localparam int MIN_RESET_CYCLES_DEF = 1024;

  // Counter width able to reach the larger of the two compare values.
  function automatic int cnt_width(input int a, input int b);
    return $clog2((a > b) ? a : b);
  endfunction

endpackage

// File: rtl/button_reset_ctrl_if.sv
// Bundle of the button pin and the three conditioned outputs.
// Latency: n/a (wires only).
// Backpressure: none; all signals are levels or single-cycle strobes.
// Ports: button_n (raw pin, low = pressed), rst_n_out (core reset, low = reset),
//        btn_level (debounced, 1 = pressed), press_pulse (one cycle per accepted press).
interface button_reset_ctrl_if;
  logic button_n;
  logic rst_n_out;
  logic btn_level;
  logic press_pulse;

  // Board side: drives the pin, consumes the conditioned signals.
  modport master (
    output button_n,
    input  rst_n_out,
    input  btn_level,
    input  press_pulse
  );

  // Conditioner side.
  modport slave (
    input  button_n,
    output rst_n_out,
    output btn_level,
    output press_pulse
  );
endinterface

// File: rtl/button_reset_ctrl_sync2.sv
// Generic two-flop synchroniser for a single asynchronous bit.
// Latency: 2 clock edges from input change to output change.
// Backpressure: none.
// Ports: i_clk, i_rst (async, active-high, loads RST_VAL), i_d (async in), o_q (synchronised out).
module button_reset_ctrl_sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= RST_VAL;
      r_q    <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/button_reset_ctrl.sv
// Debounces the board push-button and stretches it into a clean active-low core reset.
// Latency: press accepted DEBOUNCE_CYCLES edges after PRESS_DB entry; reset held MIN_RESET_CYCLES after release.
// Backpressure: none; outputs are registered levels plus a one-cycle press strobe.
// Ports: i_clk25 (25 MHz), i_rst (async active-high), bus.slave: button_n in,
//        rst_n_out / btn_level / press_pulse out.
module button_reset_ctrl
  import button_reset_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES  = DEBOUNCE_CYCLES_DEF,
  parameter int MIN_RESET_CYCLES = MIN_RESET_CYCLES_DEF
) (
  input  logic                i_clk25,
  input  logic                i_rst,
  button_reset_ctrl_if.slave  bus
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, MIN_RESET_CYCLES);

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(MIN_RESET_CYCLES - 1);

  typedef enum logic [2:0] {
    S_HOLD       = 3'd0,
    S_IDLE       = 3'd1,
    S_PRESS_DB   = 3'd2,
    S_ACTIVE     = 3'd3,
    S_RELEASE_DB = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_rst_n;
  logic             r_level;
  logic             r_pulse;
  logic             w_sync;
  logic             w_pressed;
  logic             w_pulse_nxt;

  // Synchroniser resets to "released" so a reset never looks like a press.
  button_reset_ctrl_sync2 #(
    .RST_VAL (1'b1)
  ) u_sync (
    .i_clk (i_clk25),
    .i_rst (i_rst),
    .i_d   (bus.button_n),
    .o_q   (w_sync)
  );

  assign w_pressed = ~w_sync;

  always_ff @(posedge i_clk25 or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_HOLD;
      r_cnt   <= '0;
      r_rst_n <= 1'b0;
      r_level <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      // Outputs follow the state being entered so they change on the same edge.
      r_rst_n <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_PRESS_DB);
      r_level <= (w_state_nxt == S_ACTIVE) || (w_state_nxt == S_RELEASE_DB);
      r_pulse <= w_pulse_nxt;
    end
  end

  // The counter only advances while below its compare value and is cleared
  // on every state entry, so it can never wrap.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_HOLD: begin
        if (w_pressed) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == MIN_LAST) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_IDLE: begin
        if (w_pressed) begin
          w_state_nxt = S_PRESS_DB;
          w_cnt_nxt   = '0;
        end
      end
      S_PRESS_DB: begin
        if (!w_pressed) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == DB_LAST) begin
          w_state_nxt = S_ACTIVE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_ACTIVE: begin
        if (!w_pressed) begin
          w_state_nxt = S_RELEASE_DB;
          w_cnt_nxt   = '0;
        end
      end
      S_RELEASE_DB: begin
        if (w_pressed) begin
          // Bounce while releasing: back to pressed without a new strobe.
          w_state_nxt = S_ACTIVE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == DB_LAST) begin
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_HOLD;
        w_cnt_nxt   = '0;
      end
    endcase
    // Only a freshly debounced press raises the strobe.
    w_pulse_nxt = (r_state == S_PRESS_DB) && (w_state_nxt == S_ACTIVE);
  end

  assign bus.rst_n_out   = r_rst_n;
  assign bus.btn_level   = r_level;
  assign bus.press_pulse = r_pulse;

endmodule
